serial_adder_sub: RTL and testbench

//   Parametrised bit-serial adder/subtractor: the sequential successor of the 1-bit half-adder lab cell.

---
 rtl/serial_adder_sub_pkg.sv | 21 ++
 rtl/serial_adder_sub_full_adder.sv | 17 +
 rtl/serial_adder_sub.sv | 112 +++++++++++
 tb/tb_serial_adder_sub.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the bit-counter width helper.
package serial_adder_sub_pkg;

  // State encoding; the unused code 2'd3 is steered back to S_IDLE by the FSM.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Bit counter needs to count 0..WIDTH-1, but never narrower than one bit.
  function automatic int cnt_width(input int width);
    if (width > 1) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/serial_adder_sub_full_adder.sv
// Single-bit full adder cell: the one arithmetic element the serial datapath
// reuses every clock.
module full_adder_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  // Sum and carry of three input bits.
  always_comb begin
    o_s    = i_a ^ i_b ^ i_cin;
    o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
  end

endmodule

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor. Operands are latched on an accepted start and
// resolved LSB first, one bit per clock, through a single full adder and a
// carry flip-flop. Subtraction is a + ~b + 1, the +1 entering as initial carry.
module serial_adder_sub
  import serial_adder_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  full_adder_bit u_fa (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_c)
  );

  // Shift-right values for the operand registers; the new sum bit enters the
  // result register at the MSB so that after WIDTH shifts it is aligned.
  always_comb begin
    w_a_nxt            = r_a_sh >> 1'b1;
    w_b_nxt            = r_b_sh >> 1'b1;
    w_res_nxt          = r_res >> 1'b1;
    w_res_nxt[WIDTH-1] = w_s;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_res      <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_sum      <= '0;
      o_cout     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            // Accept: sum/cout/overflow keep their old values until the new DONE.
            r_a_sh  <= i_a;
            r_b_sh  <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a_sh  <= w_a_nxt;
          r_b_sh  <= w_b_nxt;
          r_res   <= w_res_nxt;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            // r_carry here is the carry into the MSB; w_c is the carry out.
            r_state    <= S_DONE;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            o_sum      <= w_res_nxt;
            o_cout     <= w_c;
            o_overflow <= r_carry ^ w_c;
          end else begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Self-checking bench for serial_adder_sub: directed table at WIDTH=4,
// hand-written multi-cycle corner cases, and a sweep run in parallel on
// WIDTH=1, 4 and 8 instances against a behavioural model.
module tb_serial_adder_sub;

  logic clk;
  logic rst;
  logic start4, sub4;
  logic [3:0] a4, b4;
  logic busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  logic startx, sub1, sub8;
  logic [0:0] a1, b1, sum1;
  logic busy1, done1, cout1, ovf1;
  logic [7:0] a8, b8, sum8;
  logic busy8, done8, cout8, ovf8;

  int passed = 0;
  int total  = 0;

  serial_adder_sub #(.WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_sub(sub4), .i_a(a4), .i_b(b4),
    .o_busy(busy4), .o_done(done4), .o_sum(sum4), .o_cout(cout4), .o_overflow(ovf4)
  );

  serial_adder_sub #(.WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(startx), .i_sub(sub1), .i_a(a1), .i_b(b1),
    .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1), .o_overflow(ovf1)
  );

  serial_adder_sub #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(startx), .i_sub(sub8), .i_a(a8), .i_b(b8),
    .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_cout(cout8), .o_overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Counts edges after an accept until done4 rises; 99 if it never does.
  task automatic wait_done4(output int lat);
    lat = 99;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done4) begin
        lat = k;
        break;
      end
    end
  endtask

  // Behavioural reference: unsigned sum modulo 2^w, carry out (1 = no borrow
  // when subtracting), and overflow from the true signed result range.
  task automatic model(input int w, input int a, input int b, input bit sub,
                       output int s, output int c, output int v);
    longint mask, half, u, sa, sb, r;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    u    = sub ? (longint'(a) + ((~longint'(b)) & mask) + 64'd1) : (longint'(a) + longint'(b));
    s    = int'(u & mask);
    c    = int'((u >> w) & 64'd1);
    sa   = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
    sb   = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
    r    = sub ? sa - sb : sa + sb;
    v    = ((r < -half) || (r >= half)) ? 1 : 0;
  endtask

  initial begin
    int lat, cnt_done, cnt_busy;
    int lat1, lat4, lat8;
    int es, ec, ev;

    vecs[0] = '{4'd3,  4'd5, 1'b0, 4'd8,  1'b0, 1'b1};
    vecs[1] = '{4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0};
    vecs[2] = '{4'd5,  4'd3, 1'b1, 4'd2,  1'b1, 1'b0};
    vecs[3] = '{4'd3,  4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
    vecs[4] = '{4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1};
    vecs[5] = '{4'd7,  4'd1, 1'b0, 4'd8,  1'b0, 1'b1};
    vecs[6] = '{4'd0,  4'd0, 1'b1, 4'd0,  1'b1, 1'b0};

    rst = 1'b1; start4 = 1'b0; sub4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    startx = 1'b0; sub1 = 1'b0; sub8 = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", int'(busy4), 0);
    chk("reset_done", int'(done4), 0);
    chk("reset_sum",  int'(sum4),  0);
    chk("reset_cout", int'(cout4), 0);
    chk("reset_ovf",  int'(ovf4),  0);

    // Directed table
    foreach (vecs[i]) begin
      a4 = vecs[i].a; b4 = vecs[i].b; sub4 = vecs[i].sub; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      chk("vec_busy_after_accept", int'(busy4), 1);
      wait_done4(lat);
      chk("vec_latency", lat, 4);
      chk("vec_busy_at_done", int'(busy4), 0);
      chk("vec_sum",  int'(sum4),  int'(vecs[i].sum));
      chk("vec_cout", int'(cout4), int'(vecs[i].cout));
      chk("vec_ovf",  int'(ovf4),  int'(vecs[i].ovf));
      tick();
      chk("vec_done_one_cycle", int'(done4), 0);
    end

    // Start during RUN is ignored; start in DONE chains with no IDLE cycle
    a4 = 4'd3; b4 = 4'd5; sub4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    a4 = 4'd15; b4 = 4'd1; sub4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_done4(lat);
    chk("ignore_latency", lat, 1);
    chk("ignore_sum",  int'(sum4),  8);
    chk("ignore_cout", int'(cout4), 0);
    chk("ignore_ovf",  int'(ovf4),  1);
    a4 = 4'd5; b4 = 4'd3; sub4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("b2b_busy", int'(busy4), 1);
    chk("b2b_done_low", int'(done4), 0);
    chk("b2b_sum_held", int'(sum4), 8);
    wait_done4(lat);
    chk("b2b_latency", lat, 4);
    chk("b2b_sum",  int'(sum4),  2);
    chk("b2b_cout", int'(cout4), 1);
    chk("b2b_ovf",  int'(ovf4),  0);

    // Reset during RUN aborts; reset beats start
    a4 = 4'd15; b4 = 4'd1; sub4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(busy4), 0);
    chk("abort_done", int'(done4), 0);
    chk("abort_sum",  int'(sum4),  0);
    chk("abort_cout", int'(cout4), 0);
    chk("abort_ovf",  int'(ovf4),  0);
    cnt_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done4) cnt_done++;
    end
    chk("abort_no_done", cnt_done, 0);
    a4 = 4'd3; b4 = 4'd5; rst = 1'b1; start4 = 1'b1;
    tick();
    rst = 1'b0; start4 = 1'b0;
    cnt_done = 0; cnt_busy = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy4) cnt_busy++;
      if (done4) cnt_done++;
      tick();
    end
    chk("rst_start_busy", cnt_busy, 0);
    chk("rst_start_done", cnt_done, 0);

    // Sweep: exhaustive on WIDTH=4 and WIDTH=1, random on WIDTH=8
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          a4 = 4'(a); b4 = 4'(b); sub4 = s[0];
          a1 = a[0:0]; b1 = b[0:0]; sub1 = a[1] ^ b[1] ^ s[0];
          a8 = 8'($urandom); b8 = 8'($urandom); sub8 = s[0];
          start4 = 1'b1; startx = 1'b1;
          tick();
          start4 = 1'b0; startx = 1'b0;
          lat1 = 99; lat4 = 99; lat8 = 99;
          for (int k = 1; k <= 12; k++) begin
            tick();
            if (done1 && lat1 == 99) lat1 = k;
            if (done4 && lat4 == 99) lat4 = k;
            if (done8 && lat8 == 99) lat8 = k;
            if (lat1 != 99 && lat4 != 99 && lat8 != 99) break;
          end
          chk("sweep_lat_w1", lat1, 1);
          chk("sweep_lat_w4", lat4, 4);
          chk("sweep_lat_w8", lat8, 8);
          model(4, a, b, s[0], es, ec, ev);
          chk("sweep_w4", int'({sum4, cout4, ovf4}), (es << 2) | (ec << 1) | ev);
          model(1, int'(a1), int'(b1), sub1, es, ec, ev);
          chk("sweep_w1", int'({sum1, cout1, ovf1}), (es << 2) | (ec << 1) | ev);
          model(8, int'(a8), int'(b8), sub8, es, ec, ev);
          chk("sweep_w8", int'({sum8, cout8, ovf8}), (es << 2) | (ec << 1) | ev);
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
